// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and constants for the sliced CLA add sequencer.
package cla_add_sequencer_pkg;
  localparam int SLICE_W = 16;
  localparam int NREQ    = 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cla_add_sequencer_cla.sv
// 16-bit two-level carry look-ahead adder (4-bit groups, group look-ahead); purely combinational.
module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p, g, c;
  logic [3:0]  gp, gg, gc;

  // Carries into each of four positions from propagate/generate, fully expanded.
  function automatic logic [3:0] lookahead(input logic [3:0] pp, input logic [3:0] gg_in, input logic ci);
    logic [3:0] cc;
    cc[0] = ci;
    cc[1] = gg_in[0] | (pp[0] & ci);
    cc[2] = gg_in[1] | (pp[1] & gg_in[0]) | (pp[1] & pp[0] & ci);
    cc[3] = gg_in[2] | (pp[2] & gg_in[1]) | (pp[2] & pp[1] & gg_in[0]) | (pp[2] & pp[1] & pp[0] & ci);
    return cc;
  endfunction

  always_comb begin
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    gc   = lookahead(gp, gg, cin);
    cout = gg[3] | (gp[3] & gc[3]);
    c    = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j +: 4] = lookahead(p[4*j +: 4], g[4*j +: 4], gc[j]);
    end
    sum = p ^ c;
  end
endmodule

// File: rtl/cla_add_sequencer.sv
// Two-requester round-robin adder that walks WIDTH/16 slices through one shared 16-bit CLA.
// Optional subtract support is enabled by defining CLA_ADD_SEQUENCER_SUB_EN.
module cla_add_sequencer
  import cla_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
`ifdef CLA_ADD_SEQUENCER_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int OFF_W  = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              id_q, id_d, last_q, last_d, vld_q, vld_d;

  logic [NREQ-1:0]   gnt;
  logic              accept, sel_cin;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [OFF_W-1:0]  off;
  logic [SLICE_W-1:0] slice_sum;
  logic              slice_cout;

  always_comb begin
    gnt    = '0;
    gnt[0] = req0_valid & (~req1_valid | last_q);
    gnt[1] = req1_valid & (~req0_valid | ~last_q);
  end

  assign req0_ready = ~rst & (state_q == IDLE) & gnt[0];
  assign req1_ready = ~rst & (state_q == IDLE) & gnt[1];
  assign accept     = req0_ready | req1_ready;

  // Subtraction is folded in at accept time so the slice datapath only ever adds.
  always_comb begin
    sel_a   = gnt[1] ? req1_a   : req0_a;
    sel_b   = gnt[1] ? req1_b   : req0_b;
    sel_cin = gnt[1] ? req1_cin : req0_cin;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
    if (gnt[1] ? req1_sub : req0_sub) begin
      sel_b   = ~sel_b;
      sel_cin = 1'b1;
    end
`endif
  end

  assign off = OFF_W'(idx_q * SLICE_W);

  carry_look_ahead_16bit u_cla (
    .a    (a_q[off +: SLICE_W]),
    .b    (b_q[off +: SLICE_W]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        a_d     = sel_a;
        b_d     = sel_b;
        carry_d = sel_cin;
        id_d    = gnt[1];
        last_d  = gnt[1];
        idx_d   = '0;
        sum_d   = '0;
      end
      RUN: begin
        sum_d[off +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NSLICE - 1)) state_d = DONE;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    vld_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
    end
  end

  assign rsp_valid = vld_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_cla_add_sequencer.sv
// Randomized bench for cla_add_sequencer against an arithmetic reference model, plus directed literal cases.
module tb_cla_add_sequencer;
  localparam int W  = 64;
  localparam int NS = W / 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, rsp_valid, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
  logic         req0_sub, req1_sub;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one operation in flight, result known at accept time.
  bit           m_busy, m_done, m_last, m_id, m_cout;
  int           m_cnt;
  logic [W-1:0] m_sum;
  int           hs_ids[$];

  always #5 clk = ~clk;

  cla_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
`ifdef CLA_ADD_SEQUENCER_SUB_EN
    .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    bit           idle, e0, e1, sel, s;
    logic [W-1:0] a, b;
    logic [W:0]   tot;
    bit           c;
    if (rst) begin
      m_busy = 0; m_done = 0; m_last = 1; m_id = 0; m_cout = 0; m_sum = '0; m_cnt = 0;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_cout", rsp_cout, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
    end else begin
      idle = !m_busy && !m_done;
      e0 = idle && req0_valid && (!req1_valid || m_last);
      e1 = idle && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, m_done);
      if (m_done) begin
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_cout", rsp_cout, m_cout);
        chk("rsp_id", rsp_id, m_id);
      end
      if (m_done) begin
        if (rsp_ready) begin m_done = 0; hs_ids.push_back(int'(rsp_id)); end
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
      end else if (e0 || e1) begin
        sel = e1;
        a = sel ? req1_a : req0_a;
        b = sel ? req1_b : req0_b;
        c = sel ? req1_cin : req0_cin;
        s = 0;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
        s = sel ? req1_sub : req0_sub;
`endif
        tot = s ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
        m_sum = tot[W-1:0]; m_cout = tot[W]; m_id = sel; m_last = sel; m_busy = 1; m_cnt = NS;
      end
    end
  end

  task automatic step();
    bit acc0, acc1;
    @(negedge clk);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    if (acc0) req0_valid = 0;
    if (acc1) req1_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    if (!rsp_valid) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (req0_valid || req1_valid || m_busy || m_done); i++) begin
      rsp_ready = 1; step();
    end
    chk("drain_idle", {req0_valid, req1_valid, m_busy, m_done}, 0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return '1;
      1: return '0;
      2: return {{(W-16){1'b0}}, 16'hFFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0; req0_cin = 0; req1_cin = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
`ifdef CLA_ADD_SEQUENCER_SUB_EN
    req0_sub = 0; req1_sub = 0;
`endif
    do_reset();

    // Carry ripple through every slice, with latency measured from the accept edge.
    req0_a = '1; req0_b = 64'd1; req0_cin = 0; req0_valid = 1;
    step();
    chk("ripple_accepted", req0_valid, 0);
    wait_valid("ripple", n);
    chk("ripple_latency", n, NS);
    chk("ripple_sum", rsp_sum, 0);
    chk("ripple_cout", rsp_cout, 1);
    chk("ripple_id", rsp_id, 0);
    drain();

    // Ties after reset alternate starting with requester 0.
    do_reset();
    hs_ids.delete();
    req0_a = 64'd10; req0_b = 64'd20; req0_cin = 0;
    req1_a = 64'd30; req1_b = 64'd40; req1_cin = 1;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 60 && hs_ids.size() < 2; i++) step();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 60 && hs_ids.size() < 4; i++) step();
    chk("tie_count", hs_ids.size(), 4);
    chk("tie_first", hs_ids[0], 0);
    chk("tie_second", hs_ids[1], 1);
    chk("tie_third", hs_ids[2], 0);
    drain();

    // Response stall: held result, no accepts while both requesters wait.
    rsp_ready = 0;
    req0_a = 64'h8000_0000_0000_0001; req0_b = 64'h8000_0000_0000_0002; req0_cin = 0; req0_valid = 1;
    step();
    wait_valid("stall", n);
    req0_a = 64'd1; req0_b = 64'd1; req0_valid = 1;
    req1_a = 64'd2; req1_b = 64'd2; req1_valid = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_sum", rsp_sum, 64'd3);
      chk("stall_cout", rsp_cout, 1);
      chk("stall_id", rsp_id, 0);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1;
    step();
    chk("stall_release", rsp_valid, 0);
    drain();

    // Reset during slice 2 aborts, then the block recovers.
    req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_valid = 1;
    step(); step(); step();
    rst = 1;
    step();
    chk("abort_valid", rsp_valid, 0);
    chk("abort_sum", rsp_sum, 0);
    rst = 0;
    step();
    req0_a = 64'h0000_0000_FFFF_0000; req0_b = 64'h0000_0000_0001_0000; req0_cin = 1; req0_valid = 1;
    step();
    wait_valid("recover", n);
    chk("recover_latency", n, NS);
    chk("recover_sum", rsp_sum, 64'h0000_0001_0000_0001);
    chk("recover_cout", rsp_cout, 0);
    drain();

`ifdef CLA_ADD_SEQUENCER_SUB_EN
    req0_sub = 1; req0_cin = 0; req0_a = 64'd5; req0_b = 64'd7; req0_valid = 1;
    step();
    wait_valid("sub_neg", n);
    chk("sub_neg_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_neg_cout", rsp_cout, 0);
    drain();
    req0_sub = 1; req0_cin = 0; req0_a = 64'd7; req0_b = 64'd5; req0_valid = 1;
    step();
    wait_valid("sub_pos", n);
    chk("sub_pos_sum", rsp_sum, 64'd2);
    chk("sub_pos_cout", rsp_cout, 1);
    drain();
    req0_sub = 0;
`endif

    // Random traffic; idle requesters scramble their operands every cycle.
    for (int i = 0; i < 1500; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid) begin
        req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom);
`ifdef CLA_ADD_SEQUENCER_SUB_EN
        req0_sub = 1'($urandom);
`endif
        req0_valid = ($urandom_range(0, 2) == 0);
      end
      if (!req1_valid) begin
        req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom);
`ifdef CLA_ADD_SEQUENCER_SUB_EN
        req1_sub = 1'($urandom);
`endif
        req1_valid = ($urandom_range(0, 2) == 0);
      end
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
